// File: rtl/tstate_seq.sv
// tstate_seq: parametrised T-state sequencer for the control unit.
// Produces the micro-step number T. T advances on the falling edge of clk,
// wraps to 0 after LAST_T or on an early end-of-instruction (eoi), and holds
// while stall is high. Every return to T0 counts one retired instruction.
// T itself is the sequencer state; it is exported directly on port T.
// Optional feature macro: TSTATE_ONEHOT_EN adds a registered one-hot decode
// of T on T_onehot. Without the macro, T_onehot is tied to zero.
module tstate_seq #(
  parameter int TBITS    = 3,
  parameter int LAST_T   = 7,
  parameter int ICOUNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                eoi,
  output logic [TBITS-1:0]    T,
  output logic                last,
  output logic [LAST_T:0]     T_onehot,
  output logic [ICOUNT_W-1:0] icount
);

  localparam logic [TBITS-1:0] LAST_T_V = LAST_T[TBITS-1:0];

  logic [TBITS-1:0]    t_q, t_d;
  logic [ICOUNT_W-1:0] icount_q, icount_d;
  logic                wrap;

  // Any T at or above LAST_T returns to T0, so a corrupted T self-recovers.
  assign wrap = eoi || (t_q >= LAST_T_V);

  // Next T-state and instruction count; stall freezes everything and drops eoi.
  always_comb begin
    t_d      = t_q;
    icount_d = icount_q;
    if (!stall) begin
      if (wrap) begin
        t_d      = '0;
        icount_d = icount_q + ICOUNT_W'(1);
      end else begin
        t_d = t_q + TBITS'(1);
      end
    end
  end

  // State register: falling-edge clocked, async reset to T0 with zero count.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      t_q      <= '0;
      icount_q <= '0;
    end else begin
      t_q      <= t_d;
      icount_q <= icount_d;
    end
  end

  assign T      = t_q;
  assign icount = icount_q;

  // Early warning for microcode prefetch: the coming edge returns T to 0.
  assign last = !reset && !stall && wrap;

`ifdef TSTATE_ONEHOT_EN
  logic [LAST_T:0] onehot_q, onehot_d;

  // Decode from the next T so the one-hot register stays aligned with t_q.
  always_comb begin
    onehot_d = '0;
    for (int i = 0; i <= LAST_T; i++) begin
      onehot_d[i] = (t_d == i[TBITS-1:0]);
    end
  end

  // One-hot register: same edges and reset as T, reset value is T0 decoded.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      onehot_q <= {{LAST_T{1'b0}}, 1'b1};
    end else begin
      onehot_q <= onehot_d;
    end
  end

  assign T_onehot = onehot_q;
`else
  assign T_onehot = '0;
`endif

endmodule

// File: tb/tb_tstate_seq.sv
// tb_tstate_seq: directed bench for tstate_seq. Two instances share clk and
// reset: dut0 with default parameters, dut2 with TBITS=4, LAST_T=9,
// ICOUNT_W=2. Stimulus is applied just after each rising edge and the
// expected outputs for that half-cycle are queued; a monitor compares them
// shortly afterwards, before the falling edge that advances the sequencer.
module tb_tstate_seq;

  typedef struct packed {
    logic        sel;   // 0 = dut0, 1 = dut2
    logic [3:0]  t;
    logic [15:0] ic;
    logic        lst;
    logic [15:0] oh;
  } exp_t;

  exp_t exp_q[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0;
  logic eoi = 1'b0;
  logic stall2 = 1'b0;
  logic eoi2 = 1'b0;

  logic [2:0]  t0;
  logic        last0;
  logic [7:0]  oh0;
  logic [15:0] ic0;

  logic [3:0]  t2;
  logic        last2;
  logic [9:0]  oh2;
  logic [1:0]  ic2;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  tstate_seq dut0 (
    .clk(clk), .reset(reset), .stall(stall), .eoi(eoi),
    .T(t0), .last(last0), .T_onehot(oh0), .icount(ic0)
  );

  tstate_seq #(.TBITS(4), .LAST_T(9), .ICOUNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall2), .eoi(eoi2),
    .T(t2), .last(last2), .T_onehot(oh2), .icount(ic2)
  );

  function automatic logic [15:0] onehot_exp(input int t);
`ifdef TSTATE_ONEHOT_EN
    logic [15:0] one;
    one = 16'd1;
    return one << t;
`else
    return 16'd0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic s, input logic e,
                      input int et, input int eic, input logic el);
    exp_t x;
    @(posedge clk);
    #1;
    reset = r;
    stall = s;
    eoi   = e;
    x.sel = 1'b0;
    x.t   = et[3:0];
    x.ic  = eic[15:0];
    x.lst = el;
    x.oh  = onehot_exp(et);
    exp_q.push_back(x);
  endtask

  task automatic step2(input int et, input int eic, input logic el);
    exp_t x;
    @(posedge clk);
    #1;
    x.sel = 1'b1;
    x.t   = et[3:0];
    x.ic  = eic[15:0];
    x.lst = el;
    x.oh  = onehot_exp(et);
    exp_q.push_back(x);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t x;
    logic [3:0]  at;
    logic [15:0] aic;
    logic        al;
    logic [15:0] aoh;
    forever begin
      @(posedge clk);
      #2;
      while (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        if (x.sel == 1'b0) begin
          at = {1'b0, t0}; aic = ic0; al = last0; aoh = {8'd0, oh0};
        end else begin
          at = t2; aic = {14'd0, ic2}; al = last2; aoh = {6'd0, oh2};
        end
        checks++;
        if (at !== x.t || aic !== x.ic || al !== x.lst || aoh !== x.oh) begin
          errors++;
          $display("FAIL dut%0d_state @%0t: got T=%0d icount=%0d last=%0d onehot=%0h, want T=%0d icount=%0d last=%0d onehot=%0h",
                   x.sel ? 2 : 0, $time, at, aic, al, aoh, x.t, x.ic, x.lst, x.oh);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset held: T=0, icount=0, one-hot bit 0, last=0.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // Free run from release: 0..7, last at 7, then wrap with icount=1.
    for (int k = 0; k < 8; k++) step(0, 0, 0, k, 0, k == 7);
    step(0, 0, 0, 0, 1, 0);
    // Early end of instruction at T=3.
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 2, 1, 0);
    step(0, 0, 1, 3, 1, 1);
    step(0, 0, 0, 0, 2, 0);
    step(0, 0, 0, 1, 2, 0);
    // Stall with eoi at T=2 for three edges: nothing moves, eoi dropped.
    for (int k = 0; k < 3; k++) step(0, 1, 1, 2, 2, 0);
    step(0, 0, 0, 2, 2, 0);
    step(0, 0, 0, 3, 2, 0);
    // Coincident eoi at LAST_T: single increment.
    step(0, 0, 0, 4, 2, 0);
    step(0, 0, 0, 5, 2, 0);
    step(0, 0, 0, 6, 2, 0);
    step(0, 0, 1, 7, 2, 1);
    // eoi in T0: one-cycle instructions.
    step(0, 0, 1, 0, 3, 1);
    step(0, 0, 1, 0, 4, 1);
    step(0, 0, 0, 0, 5, 0);
    for (int k = 1; k < 5; k++) step(0, 0, 0, k, 5, 0);
    // T is now 5: raise reset between edges, effect seen before next edge.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    // dut2 left reset together with dut0: T runs 0..9, icount wraps mod 4.
    for (int n = 2; n <= 40; n++) step2(n % 10, (n / 10) % 4, (n % 10) == 9);
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tstate_seq.md
# tstate_seq

Parametrised T-state sequencer, the successor to the fixed 3-bit T-state counter. Generates the micro-step number T for the control unit. Adds configurable step width and wrap point, an early end-of-instruction restart, a stall hold, and a retired-instruction counter. Sits between the clock generator and the microcode ROM address logic.

## Interface

**Parameters**
- `TBITS`, default 3: width of T.
- `LAST_T`, default 7: final T-state; T wraps to 0 after it. Must satisfy 1 ≤ `LAST_T` ≤ 2^`TBITS`−1.
- `ICOUNT_W`, default 16: width of the retired-instruction counter.

**Ports**
- `clk`, input, 1: system clock. All state advances on the falling edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `stall`, input, 1: hold all state this cycle.
- `eoi`, input, 1: end of instruction. Restart at T0 on the next falling edge.
- `T`, output, `TBITS`: current T-state.
- `last`, output, 1: combinational. 1 when the next edge returns T to 0 (`T`==`LAST_T` or `eoi`) and `stall`=0.
- `T_onehot`, output, `LAST_T`+1: one-hot decode of T (see Configuration).
- `icount`, output, `ICOUNT_W`: count of completed instructions.

## Operation

- **Reset** (async, immediate, independent of `clk`):
  - `T`=0
  - `icount`=0
  - `T_onehot`=1 (bit 0 set) when enabled, else 0
  - `last`=0
- **Priority at each falling edge:** `reset` > `stall` > `eoi` > normal increment.
- **`stall`=1:** `T` and `icount` hold. `eoi` is ignored that cycle, not latched for later.
- **`eoi`=1, `stall`=0:**
  - `T`←0.
  - `icount`←`icount`+1.
  - Applies in any T-state, including T0. In T0 it gives a 1-cycle instruction.
- **`T`==`LAST_T`, `stall`=0:** `T`←0, `icount`←`icount`+1. If `eoi` is also 1, `icount` increments once, not twice.
- **Otherwise:** `T`←`T`+1.
- **Wrap-around:**
  - `icount` wraps modulo 2^`ICOUNT_W` with no flag.
  - `T` never exceeds `LAST_T`.
- **Out-of-range `T`:** a value above `LAST_T` cannot arise from normal operation. If present, the next unstalled edge sets it to 0 and counts an instruction.
- **`reset` deassertion:** the first falling edge after `reset` falls advances `T` to 1, unless `stall` or `eoi` is asserted.

## Timing

- Registered outputs `T`, `icount` and `T_onehot` change only on the falling edge of `clk` or on the async assertion of `reset`.
- Latency is one falling edge from input to effect.
  - `stall` and `eoi` are sampled at the falling edge.
  - Upstream logic must drive them stable from the preceding rising edge.
- `last` is combinational from `T`, `eoi` and `stall`. It is valid within the same half-cycle, so microcode can prefetch.
- With `LAST_T`=7 and no `eoi`/`stall`, `T` runs 0,1,…,7,0 with a period of 8 cycles, and `icount` increments once per period.
- Asserting `reset` mid-sequence forces `T`=0 within propagation delay, without waiting for a clock edge.

## Configuration

- **Macro `TSTATE_ONEHOT_EN`:**
  - **Defined:** `T_onehot` is a register, updated on the same edges as `T`, with exactly bit `T` set. Its reset value is 1.
  - **Undefined:** the port remains and is tied to all zeros. No decode flops are synthesised. The control unit must then decode `T` itself.

## Test plan

- **Reset and free run:** assert `reset`, then release with defaults.
  - During reset: `T`=0, `icount`=0, `T_onehot`=8'b00000001.
  - After 7 falling edges: `T`=7, `last`=1.
  - On the 8th edge: `T`=0, `icount`=1.
- **Early end of instruction:** at `T`=3, assert `eoi` for one cycle.
  - `last`=1 immediately.
  - Next edge: `T`=0, `icount`+1.
  - Following edge: `T`=1.
- **Stall:** at `T`=2, hold `stall`=1 with `eoi`=1 for 3 edges.
  - `T` stays 2 and `icount` is unchanged.
  - `last`=0 throughout.
  - After release with `eoi`=0, the next edge gives `T`=3.
- **Coincident events:**
  - At `T`=`LAST_T` with `eoi`=1: `icount` increments by exactly 1.
  - At `T`=0 with `eoi`=1: `T` stays 0 and `icount`+1 per edge.
- **Parameters and wrap:** `TBITS`=4, `LAST_T`=9, `ICOUNT_W`=2.
  - `T` runs 0..9 then 0.
  - After 4 instructions, `icount`=0.
  - With `TSTATE_ONEHOT_EN` defined, `T_onehot`=10'b1000000000 at `T`=9.
  - With the macro undefined, `T_onehot`=0.
- **Async reset mid-run:** at `T`=5, raise `reset` between edges.
  - `T`=0 and `icount`=0 before the next edge.
  - Values hold until `reset` falls.
